img_streamer: RTL and testbench
===============================

IMG_STREAMER -- requirements
Module: img_streamer

Interface
REQ-001 SHALL have parameter IMG_DIM, default 20, image width and height in pixels.
REQ-002 SHALL have parameter BIT_LENGTH, default 5, bits per pixel.
REQ-003 SHALL have parameter EDGE_CNT, default 400, number of edge bits collected per frame.
REQ-004 SHALL have parameter TIMEOUT, default 4095, maximum wait cycles for the first readable_in.
REQ-005 SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port wr_en, input, 1, frame-buffer write strobe.
REQ-008 SHALL have port wr_addr, input, 9, raster pixel index 0..399.
REQ-009 SHALL have port wr_data, input, BIT_LENGTH, pixel value.
REQ-010 SHALL have port start, input, 1, begin transmit-and-collect.
REQ-011 SHALL have port pixel_out0..pixel_out4, output, BIT_LENGTH each, five consecutive raster pixels per beat.
REQ-012 SHALL have port load_end, output, 1, marks the final transmit beat.
REQ-013 SHALL have port edge_in, input, 1, serial edge bit from the edge-detector core.
REQ-014 SHALL have port readable_in, input, 1, edge_in valid this cycle.
REQ-015 SHALL have port busy, output, 1, high in SEND, WAIT and COLLECT.
REQ-016 SHALL have port done, output, 1, high in DONE.
REQ-017 SHALL have port err, output, 1, timeout flag.
REQ-018 SHALL have port rd_addr, input, 9, edge-map read index.
REQ-019 SHALL have port rd_edge, output, 1, combinational edge-map bit at rd_addr.

Function
REQ-020 SHALL hold a frame buffer of IMG_DIM*IMG_DIM x BIT_LENGTH bits and an edge map of EDGE_CNT x 1 bit.
REQ-021 SHALL write wr_data to frame[wr_addr] on a clock edge with wr_en=1 in IDLE or DONE; wr_en SHALL be ignored in other states and for wr_addr >= 400.
REQ-022 SHALL implement an FSM with states IDLE, SEND, WAIT, COLLECT and DONE.
REQ-023 SHALL move from IDLE or DONE to SEND when start=1, clearing the beat counter, edge counter, wait counter and err; start SHALL be ignored while busy.
REQ-024 In SEND, beat b (0..79) SHALL drive pixel_outj = frame[5b+j] for j=0..4, one beat per cycle, with no gaps; the first beat appears in the cycle after start is sampled.
REQ-025 SHALL assert load_end only during beat 79, coincident with its pixels, for exactly 1 cycle, then move to WAIT.
REQ-026 Outside SEND, pixel_out0..4 SHALL be 0 and load_end SHALL be 0.
REQ-027 In WAIT, the wait counter SHALL increment each cycle; readable_in=1 SHALL move to COLLECT and capture that cycle's edge_in as bit 0.
REQ-028 If the wait counter reaches TIMEOUT in WAIT, the FSM SHALL move to DONE with err=1.
REQ-029 In COLLECT, each cycle with readable_in=1 SHALL store edge_in at edge[edge_cnt] and increment edge_cnt; cycles with readable_in=0 SHALL be held without storing.
REQ-030 When the EDGE_CNT-th bit is stored, the FSM SHALL move to DONE the next cycle; further readable_in SHALL be ignored.
REQ-031 DONE SHALL hold done=1 until start; rd_edge SHALL reflect the stored map. The edge map SHALL NOT be cleared on re-start, only overwritten.
REQ-032 readable_in in IDLE, SEND or DONE SHALL be ignored.
REQ-033 The beat, edge and wait counters SHALL be wide enough not to wrap before their terminal values (7, 9 and 12 bits).

Reset
REQ-034 Asserting reset at any time, including mid-SEND or mid-COLLECT, SHALL force IDLE and drive busy=0, done=0, err=0, load_end=0, pixel_out0..4=0, clear all counters, and clear the frame buffer and edge map to 0.

Verification
- Load frame[i]=i mod 32, pulse start -> beat 0 = (0,1,2,3,4), beat 79 = (11,12,13,14,15) with load_end=1, busy=1 for 80 cycles before WAIT.
- After SEND, drive readable_in=1 for 400 cycles with edge_in=i[0] -> done=1 one cycle after the last bit; rd_addr=7 gives 1, rd_addr=8 gives 0.
- readable_in toggled 1/0 during COLLECT -> only 400 valid bits stored, in order; done is reached after 799 cycles.
- No readable_in after SEND -> done=1 and err=1 exactly TIMEOUT cycles after entering WAIT.
- wr_en and start pulsed during SEND -> frame is unchanged and the transmission is unaffected; a subsequent start from DONE resends the identical beats.
- reset asserted at beat 40 -> all outputs 0 immediately, state IDLE, rd_edge=0 for all addresses.

Source files
------------

// File: rtl/img_streamer.sv
// Frame-buffer streamer: sends 5 pixels per beat to an edge-detector core, then collects its serial edge map.
// Pixel beats are combinational from the beat pointer; edge bits are taken only on readable_in.
module img_streamer #(
  parameter int IMG_DIM    = 20,
  parameter int BIT_LENGTH = 5,
  parameter int EDGE_CNT   = 400,
  parameter int TIMEOUT    = 4095
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [8:0]            wr_addr,
  input  logic [BIT_LENGTH-1:0] wr_data,
  input  logic                  start,
  output logic [BIT_LENGTH-1:0] pixel_out0,
  output logic [BIT_LENGTH-1:0] pixel_out1,
  output logic [BIT_LENGTH-1:0] pixel_out2,
  output logic [BIT_LENGTH-1:0] pixel_out3,
  output logic [BIT_LENGTH-1:0] pixel_out4,
  output logic                  load_end,
  input  logic                  edge_in,
  input  logic                  readable_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [8:0]            rd_addr,
  output logic                  rd_edge
);

  localparam int NPIX   = IMG_DIM * IMG_DIM;
  localparam int NBEATS = NPIX / 5;
  localparam int BEAT_W = $clog2(NBEATS + 1);
  localparam int EDGE_W = $clog2(EDGE_CNT + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEND    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_COLLECT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]            r_state;
  logic [BEAT_W-1:0]     r_beat;
  logic [8:0]            r_base;
  logic [EDGE_W-1:0]     r_edge_cnt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic                  r_err;
  logic [BIT_LENGTH-1:0] r_frame [NPIX];
  logic [EDGE_CNT-1:0]   r_edge;

  logic                  w_send;
  logic                  w_idle_like;
  logic                  w_last_beat;
  logic [BIT_LENGTH-1:0] w_pix [5];

  assign w_send      = (r_state == S_SEND);
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_last_beat = w_send && (r_beat == BEAT_W'(NBEATS - 1));

  // r_base tracks 5*beat so the pixel read needs no multiplier.
  always_comb begin
    for (int j = 0; j < 5; j++) begin
      w_pix[j] = w_send ? r_frame[r_base + 9'(j)] : '0;
    end
  end

  assign pixel_out0 = w_pix[0];
  assign pixel_out1 = w_pix[1];
  assign pixel_out2 = w_pix[2];
  assign pixel_out3 = w_pix[3];
  assign pixel_out4 = w_pix[4];
  assign load_end   = w_last_beat;
  assign busy       = w_send || (r_state == S_WAIT) || (r_state == S_COLLECT);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign rd_edge    = (32'(rd_addr) < EDGE_CNT) ? r_edge[rd_addr] : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_base     <= '0;
      r_edge_cnt <= '0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
      r_edge     <= '0;
      for (int i = 0; i < NPIX; i++) begin
        r_frame[i] <= '0;
      end
    end else begin
      if (wr_en && w_idle_like && (32'(wr_addr) < NPIX)) begin
        r_frame[wr_addr] <= wr_data;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_SEND;
            r_beat     <= '0;
            r_base     <= '0;
            r_edge_cnt <= '0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
          end
        end
        S_SEND: begin
          r_beat <= r_beat + BEAT_W'(1);
          r_base <= r_base + 9'd5;
          if (w_last_beat) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A valid bit wins over a timeout landing in the same cycle.
          if (readable_in) begin
            r_edge[0]  <= edge_in;
            r_edge_cnt <= EDGE_W'(1);
            r_state    <= (EDGE_CNT == 1) ? S_DONE : S_COLLECT;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (readable_in) begin
            r_edge[r_edge_cnt] <= edge_in;
            r_edge_cnt         <= r_edge_cnt + EDGE_W'(1);
            if (r_edge_cnt == EDGE_W'(EDGE_CNT - 1)) begin
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_streamer.sv
// Randomized bench for img_streamer: beat scoreboard checked by a negedge monitor, edge map against an array model.
module tb_img_streamer;

  localparam int TIMEOUT = 4095;
  localparam int NPIX    = 400;
  localparam int NBEATS  = 80;

  typedef struct packed {
    logic [24:0] pix;
    logic        last;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [8:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic       start = 1'b0;
  logic [4:0] pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4;
  logic       load_end;
  logic       edge_in = 1'b0;
  logic       readable_in = 1'b0;
  logic       busy, done, err;
  logic [8:0] rd_addr = '0;
  logic       rd_edge;

  int    n_checks = 0;
  int    n_fail = 0;
  beat_t q_beat[$];
  logic [4:0] mf [NPIX];
  logic       me [NPIX];

  img_streamer #(.IMG_DIM(20), .BIT_LENGTH(5), .EDGE_CNT(400), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .pixel_out0(pixel_out0), .pixel_out1(pixel_out1), .pixel_out2(pixel_out2),
    .pixel_out3(pixel_out3), .pixel_out4(pixel_out4), .load_end(load_end), .edge_in(edge_in),
    .readable_in(readable_in), .busy(busy), .done(done), .err(err), .rd_addr(rd_addr),
    .rd_edge(rd_edge)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: a SEND window opens when busy rises and closes after the beat flagged last.
  logic in_win = 1'b0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      in_win    = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) in_win = 1'b1;
      if (in_win) begin
        if (q_beat.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
          in_win = 1'b0;
        end else begin
          beat_t e;
          e = q_beat.pop_front();
          check("beat_pix", {7'd0, pixel_out4, pixel_out3, pixel_out2, pixel_out1, pixel_out0}, {7'd0, e.pix});
          check("beat_load_end", {31'd0, load_end}, {31'd0, e.last});
          check("beat_busy", {31'd0, busy}, 32'd1);
          if (e.last) in_win = 1'b0;
        end
      end else begin
        check("idle_pix", {7'd0, pixel_out4, pixel_out3, pixel_out2, pixel_out1, pixel_out0}, 32'd0);
        check("idle_load_end", {31'd0, load_end}, 32'd0);
      end
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int a, input logic [4:0] d);
    wr_en = 1'b1; wr_addr = 9'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    mf[a] = d;
  endtask

  task automatic push_beats();
    for (int b = 0; b < NBEATS; b++) begin
      beat_t e;
      e.pix  = {mf[5*b+4], mf[5*b+3], mf[5*b+2], mf[5*b+1], mf[5*b]};
      e.last = (b == NBEATS - 1);
      q_beat.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the beat-0 cycle; returns in the first WAIT cycle.
  task automatic wait_send_end();
    int n = 1;
    while (!load_end && n < 200) begin
      tick();
      n++;
    end
    check("send_len", n, NBEATS);
    tick();
  endtask

  task automatic check_map(input string nm);
    int bad = 0;
    for (int a = 0; a < NPIX; a++) begin
      rd_addr = 9'(a);
      #1;
      if (rd_edge !== me[a]) bad++;
    end
    check(nm, bad, 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < NPIX; i++) begin mf[i] = '0; me[i] = 1'b0; end
    #3;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_load_end", {31'd0, load_end}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Ramp frame, full streaming collect.
    for (int i = 0; i < NPIX; i++) write_px(i, 5'(i % 32));
    push_beats();
    pulse_start();
    wait_send_end();
    check("wait_busy", {31'd0, busy}, 1);
    for (int i = 0; i < NPIX; i++) begin
      readable_in = 1'b1;
      edge_in = 1'(i % 2);
      me[i] = edge_in;
      if (i == NPIX - 1) check("done_early", {31'd0, done}, 0);
      tick();
    end
    readable_in = 1'b0;
    check("done_after_400", {31'd0, done}, 1);
    check("busy_in_done", {31'd0, busy}, 0);
    check("err_clean", {31'd0, err}, 0);
    rd_addr = 9'd7; #1;
    check("rd_edge_7", {31'd0, rd_edge}, 1);
    rd_addr = 9'd8; #1;
    check("rd_edge_8", {31'd0, rd_edge}, 0);
    for (int i = 0; i < 10; i++) begin
      readable_in = 1'b1;
      edge_in = 1'($urandom);
      tick();
    end
    readable_in = 1'b0;
    check("done_hold", {31'd0, done}, 1);
    check_map("map_ramp");

    // Random frame written in DONE, gapped collect with random bits.
    for (int i = 0; i < NPIX; i++) write_px(i, 5'($urandom));
    push_beats();
    pulse_start();
    wait_send_end();
    k = 0;
    for (int c = 0; c < 799; c++) begin
      readable_in = (c % 2 == 0);
      edge_in = 1'($urandom);
      if (readable_in) begin me[k] = edge_in; k++; end
      if (c == 798) check("done_early_gap", {31'd0, done}, 0);
      tick();
    end
    readable_in = 1'b0;
    check("done_after_799", {31'd0, done}, 1);
    check_map("map_gapped");

    // Writes, starts and readable_in during SEND are ignored; then timeout.
    push_beats();
    pulse_start();
    for (int b = 0; b < NBEATS; b++) begin
      wr_en = 1'($urandom); wr_addr = 9'($urandom_range(0, NPIX - 1)); wr_data = 5'($urandom);
      start = 1'($urandom);
      readable_in = 1'($urandom); edge_in = 1'($urandom);
      tick();
    end
    wr_en = 1'b0; start = 1'b0; readable_in = 1'b0;
    k = 0;
    while (!done && k < TIMEOUT + 20) begin
      if (k == TIMEOUT - 1) check("err_early", {31'd0, err}, 0);
      tick();
      k++;
    end
    check("timeout_cycles", k, TIMEOUT);
    check("timeout_err", {31'd0, err}, 1);
    check("timeout_busy", {31'd0, busy}, 0);
    check_map("map_kept");

    // Resend from DONE must match, then reset at beat 40.
    push_beats();
    pulse_start();
    check("err_cleared", {31'd0, err}, 0);
    repeat (40) tick();
    reset = 1'b1;
    q_beat.delete();
    #1;
    check("rst_mid_pix", {7'd0, pixel_out4, pixel_out3, pixel_out2, pixel_out1, pixel_out0}, 0);
    check("rst_mid_load_end", {31'd0, load_end}, 0);
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_done", {31'd0, done}, 0);
    check("rst_mid_err", {31'd0, err}, 0);
    for (int i = 0; i < NPIX; i++) begin mf[i] = '0; me[i] = 1'b0; end
    check_map("map_cleared");
    tick();
    reset = 1'b0;

    // Frame buffer cleared by reset, except for fresh writes.
    for (int i = 0; i < 3; i++) write_px($urandom_range(0, NPIX - 1), 5'($urandom));
    push_beats();
    pulse_start();
    wait_send_end();
    check("queue_drained", q_beat.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
